// File: rtl/seg_status_decoder.sv
// Fourteen-segment symbol set shared with the display driver, plus the
// receive-side decoder that turns the bus pattern back into a status code
// and polices the driver's transition rules.
package fourteen_segment_display;
    // Bit map: [0]a [1]b [2]c [3]d [4]e [5]f [6]g1 [7]g2
    //          [8]h [9]i [10]j [11]k [12]l [13]m [14]dp
    localparam logic [14:0] SEG_O     = 15'h003F;
    localparam logic [14:0] SEG_C     = 15'h0039;
    localparam logic [14:0] SEG_R     = 15'h10F3;
    localparam logic [14:0] SEG_W     = 15'h2836;
    localparam logic [14:0] SEG_C_DOT = 15'h4039;
    localparam logic [14:0] SEG_W_DOT = 15'h6836;
endpackage

module seg_status_decoder #(
    parameter int ALARM_CNT_W = 8,
    parameter int DWELL_W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [14:0]            seg_i,
    input  logic                   clear_i,
    output logic [2:0]             status_o,
    output logic                   status_valid_o,
    output logic                   alarm_o,
    output logic                   illegal_pattern_o,
    output logic                   illegal_transition_o,
    output logic [ALARM_CNT_W-1:0] alarm_count_o,
    output logic [DWELL_W-1:0]     dwell_o
);
    import fourteen_segment_display::*;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_COLD     = 3'd1,
        ST_OKAY     = 3'd2,
        ST_WARM     = 3'd3,
        ST_TOO_COLD = 3'd4,
        ST_TOO_WARM = 3'd5,
        ST_UNKNOWN  = 3'd7
    } status_t;

    status_t                r_status;
    logic                   r_valid;
    logic                   r_alarm;
    logic                   r_pat;
    logic                   r_trans;
    logic [ALARM_CNT_W-1:0] r_cnt;
    logic [DWELL_W-1:0]     r_dwell;

    status_t w_new;
    logic    w_legal;
    logic    w_check;
    logic    w_new_alarm;
    logic    w_entry;
    logic    w_same;

    // Exact-match decode of the bus pattern; anything unrecognised is UNKNOWN.
    always_comb begin
        w_new = ST_UNKNOWN;
        case (seg_i)
            SEG_R:     w_new = ST_RESET;
            SEG_C:     w_new = ST_COLD;
            SEG_O:     w_new = ST_OKAY;
            SEG_W:     w_new = ST_WARM;
            SEG_C_DOT: w_new = ST_TOO_COLD;
            SEG_W_DOT: w_new = ST_TOO_WARM;
            default:   w_new = ST_UNKNOWN;
        endcase
    end

    // Allowed successor set of the previous status. RESET is always reachable
    // because the driver's own reset is asynchronous to this bus.
    always_comb begin
        w_legal = 1'b0;
        if (w_new == ST_RESET) begin
            w_legal = 1'b1;
        end else begin
            case (r_status)
                ST_RESET: w_legal = (w_new == ST_COLD) || (w_new == ST_OKAY) || (w_new == ST_WARM);
                ST_COLD:  w_legal = (w_new == ST_COLD) || (w_new == ST_OKAY) || (w_new == ST_WARM)
                                 || (w_new == ST_TOO_COLD);
                ST_OKAY:  w_legal = (w_new == ST_COLD) || (w_new == ST_OKAY) || (w_new == ST_WARM);
                ST_WARM:  w_legal = (w_new == ST_COLD) || (w_new == ST_OKAY) || (w_new == ST_WARM)
                                 || (w_new == ST_TOO_WARM);
                default:  w_legal = 1'b0;
            endcase
        end
    end

    // Transition checking needs a real history on both sides of the edge.
    assign w_check     = r_valid && (r_status != ST_UNKNOWN) && (w_new != ST_UNKNOWN);
    assign w_same      = (w_new == r_status);
    assign w_new_alarm = (w_new == ST_TOO_COLD) || (w_new == ST_TOO_WARM);
    assign w_entry     = w_new_alarm && (!r_valid || !w_same);

    // Status sampling, sticky flags and saturating counters. A clear that
    // coincides with a new event still records that event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_status <= ST_RESET;
            r_valid  <= 1'b0;
            r_alarm  <= 1'b0;
            r_pat    <= 1'b0;
            r_trans  <= 1'b0;
            r_cnt    <= '0;
            r_dwell  <= '0;
        end else begin
            r_status <= w_new;
            r_valid  <= 1'b1;
            r_alarm  <= w_new_alarm;

            if (w_new == ST_UNKNOWN)    r_pat <= 1'b1;
            else if (clear_i)           r_pat <= 1'b0;

            if (w_check && !w_legal)    r_trans <= 1'b1;
            else if (clear_i)           r_trans <= 1'b0;

            if (clear_i)                r_cnt <= w_entry ? ALARM_CNT_W'(1) : '0;
            else if (w_entry && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;

            if (r_valid && w_same) begin
                if (r_dwell != '1) r_dwell <= r_dwell + 1'b1;
            end else begin
                r_dwell <= '0;
            end
        end
    end

    assign status_o             = r_status;
    assign status_valid_o       = r_valid;
    assign alarm_o              = r_alarm;
    assign illegal_pattern_o    = r_pat;
    assign illegal_transition_o = r_trans;
    assign alarm_count_o        = r_cnt;
    assign dwell_o              = r_dwell;

endmodule

// File: tb/tb_seg_status_decoder.sv
// Bench for seg_status_decoder: directed scenarios with literal expectations
// plus a randomized stream checked every cycle against a table-driven model.
module tb_seg_status_decoder;
    import fourteen_segment_display::*;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [14:0]   seg = 15'h0;
    logic          clr = 1'b0;
    logic [2:0]    status;
    logic          valid, alarm, pat, trans;
    logic [AW-1:0] cnt;
    logic [DW-1:0] dwell;

    seg_status_decoder #(.ALARM_CNT_W(AW), .DWELL_W(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .seg_i(seg), .clear_i(clr),
        .status_o(status), .status_valid_o(valid), .alarm_o(alarm),
        .illegal_pattern_o(pat), .illegal_transition_o(trans),
        .alarm_count_o(cnt), .dwell_o(dwell)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit legal [8][8];
    int m_status = 0, m_valid = 0, m_alarm = 0, m_pat = 0, m_tr = 0, m_cnt = 0, m_dw = 0;
    bit run = 1'b0;

    function automatic int decode(logic [14:0] s);
        if (s == SEG_R)     return 0;
        if (s == SEG_C)     return 1;
        if (s == SEG_O)     return 2;
        if (s == SEG_W)     return 3;
        if (s == SEG_C_DOT) return 4;
        if (s == SEG_W_DOT) return 5;
        return 7;
    endfunction

    function automatic void build_legal();
        int succ [6][$];
        succ[0] = '{0, 1, 2, 3};
        succ[1] = '{0, 1, 2, 3, 4};
        succ[2] = '{0, 1, 2, 3};
        succ[3] = '{0, 1, 2, 3, 5};
        succ[4] = '{0};
        succ[5] = '{0};
        for (int p = 0; p < 8; p++)
            for (int n = 0; n < 8; n++) legal[p][n] = 1'b0;
        for (int p = 0; p < 6; p++)
            foreach (succ[p][k]) legal[p][succ[p][k]] = 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_status = 0; m_valid = 0; m_alarm = 0; m_pat = 0; m_tr = 0; m_cnt = 0; m_dw = 0;
        end else begin
            int n;
            bit entry;
            n = decode(seg);
            entry = (n == 4 || n == 5) && (m_valid == 0 || n != m_status);
            if (clr) begin m_pat = 0; m_tr = 0; m_cnt = 0; end
            if (n == 7) m_pat = 1;
            if (m_valid == 1 && m_status != 7 && n != 7 && !legal[m_status][n]) m_tr = 1;
            if (entry) m_cnt = (m_cnt + 1 > (1 << AW) - 1) ? (1 << AW) - 1 : m_cnt + 1;
            if (m_valid == 1 && n == m_status)
                m_dw = (m_dw + 1 > (1 << DW) - 1) ? (1 << DW) - 1 : m_dw + 1;
            else
                m_dw = 0;
            m_status = n;
            m_valid  = 1;
            m_alarm  = (n == 4 || n == 5);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("status", int'(status), m_status);
            chk("valid", int'(valid), m_valid);
            chk("alarm", int'(alarm), m_alarm);
            chk("illegal_pattern", int'(pat), m_pat);
            chk("illegal_transition", int'(trans), m_tr);
            chk("alarm_count", int'(cnt), m_cnt);
            chk("dwell", int'(dwell), m_dw);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+2; inputs settle well before the next edge.
    task automatic tick(input logic [14:0] s, input logic c = 1'b0);
        seg = s;
        clr = c;
        @(posedge clk);
        #2;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [14:0] syms [6];

    initial begin
        int exp_dw [3];
        int exp_st [4];
        int exp_al [4];
        build_legal();
        syms = '{SEG_R, SEG_C, SEG_O, SEG_W, SEG_C_DOT, SEG_W_DOT};
        #1;
        // reset state
        chk("rst_status", int'(status), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_flags", int'({pat, trans}), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run = 1'b1;

        // constant OKAY: dwell climbs from zero
        exp_dw = '{0, 1, 2};
        for (int i = 0; i < 3; i++) begin
            tick(SEG_O);
            chk("okay_status", int'(status), 2);
            chk("okay_valid", int'(valid), 1);
            chk("okay_dwell", int'(dwell), exp_dw[i]);
            chk("okay_flags", int'({pat, trans}), 0);
        end

        // C, C, C_dot, R legal alarm excursion
        do_reset();
        exp_st = '{1, 1, 4, 0};
        exp_al = '{0, 0, 1, 0};
        exp_dw = '{0, 1, 0};
        tick(SEG_C);     chk("seq2_st0", int'(status), exp_st[0]); chk("seq2_al0", int'(alarm), exp_al[0]); chk("seq2_dw0", int'(dwell), 0);
        tick(SEG_C);     chk("seq2_st1", int'(status), exp_st[1]); chk("seq2_al1", int'(alarm), exp_al[1]); chk("seq2_dw1", int'(dwell), 1);
        tick(SEG_C_DOT); chk("seq2_st2", int'(status), exp_st[2]); chk("seq2_al2", int'(alarm), exp_al[2]); chk("seq2_dw2", int'(dwell), 0);
        tick(SEG_R);     chk("seq2_st3", int'(status), exp_st[3]); chk("seq2_al3", int'(alarm), exp_al[3]); chk("seq2_dw3", int'(dwell), 0);
        chk("seq2_cnt", int'(cnt), 1);
        chk("seq2_flags", int'({pat, trans}), 0);

        // illegal OKAY -> TOO_WARM, then clear
        do_reset();
        tick(SEG_O);
        tick(SEG_W_DOT);
        chk("seq3_trans", int'(trans), 1);
        chk("seq3_cnt1", int'(cnt), 1);
        tick(SEG_C_DOT);
        tick(SEG_C_DOT);
        tick(SEG_R);
        chk("seq3_trans_sticky", int'(trans), 1);
        chk("seq3_cnt2", int'(cnt), 2);
        tick(SEG_R, 1'b1);
        chk("seq3_clr_trans", int'(trans), 0);
        chk("seq3_clr_pat", int'(pat), 0);
        chk("seq3_clr_cnt", int'(cnt), 0);

        // unrecognised pattern
        tick(15'h7FFF);
        chk("unk_status", int'(status), 7);
        chk("unk_pat", int'(pat), 1);
        chk("unk_trans", int'(trans), 0);
        tick(SEG_O);
        chk("unk_then_o", int'(status), 2);
        chk("unk_pat_sticky", int'(pat), 1);
        chk("unk_trans2", int'(trans), 0);

        // saturation of alarm counter and dwell
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick(SEG_W); tick(SEG_W_DOT); tick(SEG_R);
        end
        chk("cnt_sat", int'(cnt), 255);
        for (int i = 0; i < 300; i++) tick(SEG_O);
        chk("dwell_sat", int'(dwell), 255);

        // clear coinciding with an alarm entry
        tick(SEG_C);
        tick(SEG_C_DOT, 1'b1);
        chk("clr_entry_cnt", int'(cnt), 1);

        // asynchronous reset between edges
        tick(SEG_O);
        rst_n = 1'b0;
        #1;
        chk("async_status", int'(status), 0);
        chk("async_valid", int'(valid), 0);
        chk("async_cnt", int'(cnt), 0);
        chk("async_dwell", int'(dwell), 0);
        chk("async_flags", int'({alarm, pat, trans}), 0);
        rst_n = 1'b1;
        tick(SEG_C_DOT);
        chk("first_after_rst_trans", int'(trans), 0);
        chk("first_after_rst_cnt", int'(cnt), 1);

        // randomized stream
        for (int i = 0; i < 3000; i++) begin
            logic [14:0] s;
            int r;
            r = $urandom_range(0, 99);
            if (r < 4)       s = 15'($urandom);
            else if (r < 50) s = seg;
            else             s = syms[$urandom_range(0, 5)];
            if ($urandom_range(0, 199) == 0) do_reset();
            tick(s, ($urandom_range(0, 15) == 0));
        end

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
